// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch, writeback and execute-side signals of the RV64I decode stage.
interface decode_stage_if;
    logic [63:0] DE_NPC;
    logic [31:0] DE_IR;
    logic        DE_V;
    logic        WB_V;
    logic [4:0]  WB_RD;
    logic [63:0] WB_DATA;
    logic        V_DEP_STALL;
    logic        V_DE_FE_BR_STALL;
    logic        EXE_V;
    logic [63:0] EXE_NPC;
    logic [31:0] EXE_IR;
    logic [63:0] EXE_RS1_VAL;
    logic [63:0] EXE_RS2_VAL;
    logic [63:0] EXE_IMM;
    logic [4:0]  EXE_RD;
    modport master (
        output DE_NPC, DE_IR, DE_V, WB_V, WB_RD, WB_DATA,
        input  V_DEP_STALL, V_DE_FE_BR_STALL, EXE_V, EXE_NPC, EXE_IR,
               EXE_RS1_VAL, EXE_RS2_VAL, EXE_IMM, EXE_RD
    );
    modport slave (
        input  DE_NPC, DE_IR, DE_V, WB_V, WB_RD, WB_DATA,
        output V_DEP_STALL, V_DE_FE_BR_STALL, EXE_V, EXE_NPC, EXE_IR,
               EXE_RS1_VAL, EXE_RS2_VAL, EXE_IMM, EXE_RD
    );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: RV64I decode with register file, busy scoreboard and stall-only hazard handling.
// Define DE_WB_BYPASS_EN to let a same-cycle writeback satisfy a dependency and supply its value.
module decode_stage (
    input logic           CLK,
    input logic           RESET,
    decode_stage_if.slave bus
);
    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_STORE = 7'b0100011,
                           OP_OP = 7'b0110011, OP_OP32 = 7'b0111011, OP_LOAD = 7'b0000011,
                           OP_IMM = 7'b0010011, OP_IMM32 = 7'b0011011;
    logic [31:0] ir;
    logic [6:0]  opc;
    logic [4:0]  rd, rs1, rs2;
    logic        uses_rs1, uses_rs2, writes_rd, issue, wb_wr;
    logic        hit1, hit2, hitd;
    logic [63:0] imm, rs1_val, rs2_val;
    logic [31:0] busy_q, busy_d;
    logic [63:0] rf_q [32];
    logic        exe_v_q;
    logic [63:0] exe_npc_q, exe_rs1_q, exe_rs2_q, exe_imm_q;
    logic [31:0] exe_ir_q;
    logic [4:0]  exe_rd_q;
    assign ir = bus.DE_IR;
    assign opc = ir[6:0];
    assign rd = ir[11:7];
    assign rs1 = ir[19:15];
    assign rs2 = ir[24:20];
    assign uses_rs1 = !(opc == OP_LUI || opc == OP_AUIPC || opc == OP_JAL);
    assign uses_rs2 = opc == OP_BRANCH || opc == OP_STORE || opc == OP_OP || opc == OP_OP32;
    assign writes_rd = !(opc == OP_BRANCH || opc == OP_STORE) && rd != 5'd0;
    assign wb_wr = bus.WB_V && bus.WB_RD != 5'd0;
    assign imm = (opc == OP_LOAD || opc == OP_IMM || opc == OP_IMM32 || opc == OP_JALR) ? {{52{ir[31]}}, ir[31:20]} :
                 (opc == OP_STORE)                 ? {{52{ir[31]}}, ir[31:25], ir[11:7]} :
                 (opc == OP_BRANCH)                ? {{51{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0} :
                 (opc == OP_LUI || opc == OP_AUIPC) ? {{32{ir[31]}}, ir[31:12], 12'b0} :
                 (opc == OP_JAL)                   ? {{43{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0} :
                 64'd0;
`ifdef DE_WB_BYPASS_EN
    assign hit1 = wb_wr && bus.WB_RD == rs1;
    assign hit2 = wb_wr && bus.WB_RD == rs2;
    assign hitd = wb_wr && bus.WB_RD == rd;
`else
    assign hit1 = 1'b0;
    assign hit2 = 1'b0;
    assign hitd = 1'b0;
`endif
    assign rs1_val = hit1 ? bus.WB_DATA : rf_q[rs1];
    assign rs2_val = hit2 ? bus.WB_DATA : rf_q[rs2];
    assign bus.V_DEP_STALL = bus.DE_V && ((uses_rs1 && busy_q[rs1] && !hit1) ||
                                          (uses_rs2 && busy_q[rs2] && !hit2) ||
                                          (writes_rd && busy_q[rd] && !hitd));
    assign bus.V_DE_FE_BR_STALL = bus.DE_V && (opc == OP_JAL || opc == OP_JALR || opc == OP_BRANCH);
    assign issue = bus.DE_V && !bus.V_DEP_STALL;
    // Issue's set is applied after writeback's clear so a collision leaves the register busy.
    always_comb begin
        busy_d = busy_q;
        if (wb_wr) busy_d[bus.WB_RD] = 1'b0;
        if (issue && writes_rd) busy_d[rd] = 1'b1;
        busy_d[0] = 1'b0;
    end
    always_ff @(posedge CLK) begin
        if (RESET) begin
            busy_q <= '0;
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            busy_q <= busy_d;
            if (wb_wr) rf_q[bus.WB_RD] <= bus.WB_DATA;
        end
    end
    always_ff @(posedge CLK) begin
        if (RESET) begin
            exe_v_q <= 1'b0;
            exe_npc_q <= '0;
            exe_ir_q <= '0;
            exe_rs1_q <= '0;
            exe_rs2_q <= '0;
            exe_imm_q <= '0;
            exe_rd_q <= '0;
        end else begin
            exe_v_q <= issue;
            if (issue) begin
                exe_npc_q <= bus.DE_NPC;
                exe_ir_q <= ir;
                exe_rs1_q <= rs1_val;
                exe_rs2_q <= rs2_val;
                exe_imm_q <= imm;
                exe_rd_q <= writes_rd ? rd : 5'd0;
            end
        end
    end
    assign bus.EXE_V = exe_v_q;
    assign bus.EXE_NPC = exe_npc_q;
    assign bus.EXE_IR = exe_ir_q;
    assign bus.EXE_RS1_VAL = exe_rs1_q;
    assign bus.EXE_RS2_VAL = exe_rs2_q;
    assign bus.EXE_IMM = exe_imm_q;
    assign bus.EXE_RD = exe_rd_q;
endmodule
